// File: rtl/connect4_pkg.sv
// connect4_pkg: board geometry, window ranges, player codes, FSM states and cell indexing
package connect4_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int CELLS = 42;
  localparam int NUM_WINDOWS = 69;
  localparam int H_BASE = 0;
  localparam int V_BASE = 24;
  localparam int DR_BASE = 45;
  localparam int DL_BASE = 57;
  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int cell_idx(int row, int col);
    return row * COLS + col;
  endfunction
endpackage

// File: rtl/connect4_win_checker_if.sv
// connect4_win_checker_if: start/boards in; busy/done/winner/draw/win_cells out (slave = checker)
interface connect4_win_checker_if;
  import connect4_pkg::*;
  logic start;
  logic [CELLS-1:0] in_gameboard;
  logic [CELLS-1:0] in_players_cells;
  logic busy;
  logic done;
  logic [1:0] winner;
  logic draw;
  logic [CELLS-1:0] win_cells;
  modport master (output start, in_gameboard, in_players_cells, input busy, done, winner, draw, win_cells);
  modport slave (input start, in_gameboard, in_players_cells, output busy, done, winner, draw, win_cells);
endinterface

// File: rtl/connect4_window_mask.sv
// connect4_window_mask: idx (7b) in, 42-bit mask of that window's four cells out
module connect4_window_mask
  import connect4_pkg::*;
(
  input  logic [6:0]       idx,
  output logic [CELLS-1:0] mask
);
  int rel, base, step;
  always_comb begin
    rel = int'(idx);
    base = 0;
    step = 1;
    if (rel < V_BASE) begin
      rel = rel - H_BASE;
      base = cell_idx(rel / 4, rel % 4);
      step = 1;
    end else if (rel < DR_BASE) begin
      rel = rel - V_BASE;
      base = cell_idx(rel / 7, rel % 7);
      step = COLS;
    end else if (rel < DL_BASE) begin
      rel = rel - DR_BASE;
      base = cell_idx(rel / 4, rel % 4);
      step = COLS + 1;
    end else begin
      rel = rel - DL_BASE;
      base = cell_idx(rel / 4, rel % 4 + 3);
      step = COLS - 1;
    end
    mask = (CELLS'(1) | (CELLS'(1) << step) | (CELLS'(1) << (2 * step)) | (CELLS'(1) << (3 * step))) << base;
  end
endmodule

// File: rtl/connect4_win_checker.sv
// connect4_win_checker: clk/reset plus bus (start, boards in; busy, done, winner, draw, win_cells out); scans one window per cycle
module connect4_win_checker
  import connect4_pkg::*;
(
  input logic clk,
  input logic reset,
  connect4_win_checker_if.slave bus
);
  state_t state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [CELLS-1:0] board_q, board_d, owner_q, owner_d, win_cells_q, win_cells_d, mask;
  logic [1:0] winner_q, winner_d;
  logic draw_q, draw_d, match, owner_p2;
  connect4_window_mask u_mask (.idx(idx_q), .mask(mask));
  assign owner_p2 = |(owner_q & mask);
  assign match = ((board_q & mask) == mask) && (((owner_q & mask) == mask) || !owner_p2);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    board_d = board_q;
    owner_d = owner_q;
    winner_d = winner_q;
    draw_d = draw_q;
    win_cells_d = win_cells_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SCAN;
        idx_d = '0;
        board_d = bus.in_gameboard;
        owner_d = bus.in_players_cells;
        winner_d = P_NONE;
        draw_d = 1'b0;
        win_cells_d = '0;
      end
      SCAN: if (match) begin
        winner_d = owner_p2 ? P2 : P1;
        win_cells_d = mask;
        state_d = DONE;
      end else if (idx_q == 7'(NUM_WINDOWS - 1)) begin
        draw_d = &board_q;
        state_d = DONE;
      end else begin
        idx_d = idx_q + 7'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      board_q <= '0;
      owner_q <= '0;
      winner_q <= P_NONE;
      draw_q <= 1'b0;
      win_cells_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      board_q <= board_d;
      owner_q <= owner_d;
      winner_q <= winner_d;
      draw_q <= draw_d;
      win_cells_q <= win_cells_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.winner = winner_q;
  assign bus.draw = draw_q;
  assign bus.win_cells = win_cells_q;
endmodule

// File: tb/tb_connect4_win_checker.sv
// tb_connect4_win_checker: directed scenarios against hand-computed results
module tb_connect4_win_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  logic [41:0] draw_gb, draw_pc;
  localparam logic [41:0] DIAG = 42'h1041040;
  connect4_win_checker_if bus ();
  connect4_win_checker dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic check_clear(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 0);
    check({tag, "_done"}, 64'(bus.done), 0);
    check({tag, "_winner"}, 64'(bus.winner), 0);
    check({tag, "_draw"}, 64'(bus.draw), 0);
    check({tag, "_cells"}, 64'(bus.win_cells), 0);
  endtask
  task automatic run_scan(input string tag, input logic [41:0] gb, input logic [41:0] pc, input int exp_n,
                          input logic [1:0] exp_w, input logic exp_draw, input logic [41:0] exp_cells, input bit poke);
    int n, busy_cnt;
    bit got;
    @(negedge clk);
    bus.in_gameboard = gb;
    bus.in_players_cells = pc;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check({tag, "_busy_e0"}, 64'(bus.busy), 1);
    n = 0;
    busy_cnt = 1;
    got = 0;
    while (n < 90 && !got) begin
      @(posedge clk);
      #1 n++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1;
      if (poke && n == 20) begin
        bus.start = 1'b1;
        bus.in_gameboard = '0;
        bus.in_players_cells = '1;
      end
      if (poke && n == 21) bus.start = 1'b0;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_n + 1));
    check({tag, "_winner"}, 64'(bus.winner), 64'(exp_w));
    check({tag, "_draw"}, 64'(bus.draw), 64'(exp_draw));
    check({tag, "_cells"}, 64'(bus.win_cells), 64'(exp_cells));
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, 64'(bus.done), 0);
    check({tag, "_busy_after"}, 64'(bus.busy), 0);
    check({tag, "_winner_hold"}, 64'(bus.winner), 64'(exp_w));
    check({tag, "_cells_hold"}, 64'(bus.win_cells), 64'(exp_cells));
  endtask
  task automatic expect_no_done(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (bus.done) pulses++;
    end
    check(tag, 64'(pulses), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_gameboard = '0;
    bus.in_players_cells = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        draw_gb[r*7+c] = 1'b1;
        draw_pc[r*7+c] = 1'((c >> 1) & 1) ^ 1'(r & 1);
      end
    #1 check_clear("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(bus.busy), 0);
    run_scan("empty", '0, '0, 69, 2'b00, 1'b0, '0, 0);
    run_scan("p2_horiz", 42'h78, 42'h78, 4, 2'b10, 1'b0, 42'h78, 0);
    run_scan("p1_vert", 42'h204081, '0, 25, 2'b01, 1'b0, 42'h204081, 0);
    run_scan("p1_diag", DIAG, '0, 61, 2'b01, 1'b0, DIAG, 0);
    #2 reset = 1'b1;
    #1 check_clear("async_clear");
    @(negedge clk);
    reset = 1'b0;
    run_scan("draw", draw_gb, draw_pc, 69, 2'b00, 1'b1, '0, 1);
    expect_no_done("draw_single_done", 20);
    @(negedge clk);
    bus.in_gameboard = DIAG;
    bus.in_players_cells = '0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_clear("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    expect_no_done("mid_reset_no_done", 80);
    run_scan("diag_again", DIAG, '0, 61, 2'b01, 1'b0, DIAG, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
